fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 153 +++++++++++++++
 tb/tb_fetch_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with a START/RUN/HALT controller.
//
// Holds the program counter, presents it to instruction memory, and
// captures the returned instruction into the IF/ID pipeline register.
// An EBREAK fetch parks the unit in HALT. Only a redirect or a reset
// leaves HALT.
//
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   stall        in   hold PC and IF/ID (a redirect overrides it)
//   redirect     in   load redirect_pc and flush IF/ID
//   redirect_pc  in   [Isize] redirect target byte address
//   instr_addr   out  [Isize] current PC, word aligned
//   instr_in     in   [Isize] instruction at instr_addr (combinational memory)
//   if_id_instr  out  [Isize] registered instruction
//   if_id_pc     out  [Isize] registered PC of if_id_instr
//   if_id_pc4    out  [Isize] registered if_id_pc + 4
//   if_id_valid  out  if_id_instr is a real instruction
//   halted       out  unit is in HALT
module fetch_unit #(
  parameter int unsigned      Isize    = 32,
  parameter logic [Isize-1:0] RESET_PC = Isize'(32'h0000_0000)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             stall,
  input  logic             redirect,
  input  logic [Isize-1:0] redirect_pc,
  output logic [Isize-1:0] instr_addr,
  input  logic [Isize-1:0] instr_in,
  output logic [Isize-1:0] if_id_instr,
  output logic [Isize-1:0] if_id_pc,
  output logic [Isize-1:0] if_id_pc4,
  output logic             if_id_valid,
  output logic             halted
);

  localparam logic [Isize-1:0] NOP_INSTR    = Isize'(32'h0000_0013);
  localparam logic [Isize-1:0] EBREAK_INSTR = Isize'(32'h0010_0073);
  localparam logic [Isize-1:0] RESET_PC_AL  = {RESET_PC[Isize-1:2], 2'b00};

  typedef enum logic [1:0] {
    START = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [Isize-1:0] pc_q, pc_d;
  logic [Isize-1:0] if_id_instr_q, if_id_instr_d;
  logic [Isize-1:0] if_id_pc_q, if_id_pc_d;
  logic [Isize-1:0] if_id_pc4_q, if_id_pc4_d;
  logic             if_id_valid_q, if_id_valid_d;
  logic             halted_q, halted_d;

  logic [Isize-1:0] pc_plus4_s;
  logic [Isize-1:0] redirect_al_s;
  logic             unused_redirect_lsb_s;

  // PC+4 wraps naturally modulo 2^Isize; redirect targets are forced word aligned.
  assign pc_plus4_s            = pc_q + Isize'(32'd4);
  assign redirect_al_s         = {redirect_pc[Isize-1:2], 2'b00};
  assign unused_redirect_lsb_s = ^redirect_pc[1:0];

  // Next-state and next-IF/ID computation for the fetch controller.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_pc4_d   = if_id_pc4_q;
    if_id_valid_d = if_id_valid_q;
    case (state_q)
      START: begin
        // One settling cycle after reset; stall and redirect are ignored.
        state_d = RUN;
      end
      RUN: begin
        if (redirect) begin
          pc_d          = redirect_al_s;
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
        end else if (!stall) begin
          if_id_instr_d = instr_in;
          if_id_pc_d    = pc_q;
          if_id_pc4_d   = pc_plus4_s;
          if_id_valid_d = 1'b1;
          pc_d          = pc_plus4_s;
          if (instr_in == EBREAK_INSTR) begin
            state_d = HALT;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      HALT: begin
        if (redirect) begin
          pc_d          = redirect_al_s;
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
          state_d       = RUN;
        end else if (!stall) begin
          // EBREAK is presented once; afterwards only bubbles.
          if_id_valid_d = 1'b0;
        end else begin
          state_d = HALT;
        end
      end
      default: begin
        // Illegal encoding: fall back to the post-reset state.
        state_d       = START;
        pc_d          = RESET_PC_AL;
        if_id_instr_d = NOP_INSTR;
        if_id_pc_d    = Isize'(32'd0);
        if_id_pc4_d   = Isize'(32'd0);
        if_id_valid_d = 1'b0;
      end
    endcase
    halted_d = (state_d == HALT);
  end

  // State, PC and IF/ID register update with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= START;
      pc_q          <= RESET_PC_AL;
      if_id_instr_q <= NOP_INSTR;
      if_id_pc_q    <= Isize'(32'd0);
      if_id_pc4_q   <= Isize'(32'd0);
      if_id_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_pc4_q   <= if_id_pc4_d;
      if_id_valid_q <= if_id_valid_d;
      halted_q      <= halted_d;
    end
  end

  assign instr_addr  = pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_pc4   = if_id_pc4_q;
  assign if_id_valid = if_id_valid_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed, table-driven checks of fetch_unit plus
// hand-written sequences for asynchronous reset and START behaviour.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr_addr;
  logic [31:0] instr_in;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;

  int checks;
  int errors;

  fetch_unit #(.Isize(32), .RESET_PC(32'h0000_0000)) dut (
    .clock       (clock),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_addr  (instr_addr),
    .instr_in    (instr_in),
    .if_id_instr (if_id_instr),
    .if_id_pc    (if_id_pc),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid),
    .halted      (halted)
  );

  // Instruction memory: small program at 0/4/8, a tagged pattern elsewhere.
  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0000_0000: imem = 32'h0000_0013;
      32'h0000_0004: imem = 32'h0050_0093;
      32'h0000_0008: imem = 32'h0010_0073;
      default:       imem = 32'hA000_0000 | a;
    endcase
  endfunction

  assign instr_in = imem(instr_addr);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    logic [31:0] e_addr;
    logic        e_valid;
    logic        e_halted;
  } vec_t;

  vec_t vecs[20];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_instr, input logic [31:0] e_pc,
                           input logic [31:0] e_pc4, input logic [31:0] e_addr,
                           input logic e_valid, input logic e_halted);
    check32({tag, ".if_id_instr"}, if_id_instr, e_instr);
    check32({tag, ".if_id_pc"}, if_id_pc, e_pc);
    check32({tag, ".if_id_pc4"}, if_id_pc4, e_pc4);
    check32({tag, ".instr_addr"}, instr_addr, e_addr);
    check32({tag, ".if_id_valid"}, {31'd0, if_id_valid}, {31'd0, e_valid});
    check32({tag, ".halted"}, {31'd0, halted}, {31'd0, e_halted});
  endtask

  // Drive inputs just after an edge, then sample 1 time unit after the next edge.
  task automatic step(input logic s, input logic r, input logic [31:0] rp);
    stall       = s;
    redirect    = r;
    redirect_pc = rp;
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    //          stall  redir  rpc            instr          pc             pc4            addr           v     h
    vecs[0]  = '{1'b0, 1'b0, 32'h0,         32'h0000_0013, 32'h0,         32'h0,         32'h0,         1'b0, 1'b0}; // START
    vecs[1]  = '{1'b0, 1'b0, 32'h0,         32'h0000_0013, 32'h0,         32'h4,         32'h4,         1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0,         32'h0050_0093, 32'h4,         32'h8,         32'h8,         1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,         32'h0010_0073, 32'h8,         32'hC,         32'hC,         1'b1, 1'b1}; // EBREAK
    vecs[4]  = '{1'b0, 1'b0, 32'h0,         32'h0010_0073, 32'h8,         32'hC,         32'hC,         1'b0, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,         32'h0010_0073, 32'h8,         32'hC,         32'hC,         1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, 32'h40,        32'h0000_0013, 32'h8,         32'hC,         32'h40,        1'b0, 1'b0}; // leave HALT
    vecs[7]  = '{1'b0, 1'b0, 32'h0,         32'hA000_0040, 32'h40,        32'h44,        32'h44,        1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 32'h12,        32'h0000_0013, 32'h40,        32'h44,        32'h10,        1'b0, 1'b0}; // aligned
    vecs[9]  = '{1'b1, 1'b0, 32'h0,         32'h0000_0013, 32'h40,        32'h44,        32'h10,        1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h0,         32'h0000_0013, 32'h40,        32'h44,        32'h10,        1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'h0,         32'h0000_0013, 32'h40,        32'h44,        32'h10,        1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 32'h0,         32'hA000_0010, 32'h10,        32'h14,        32'h14,        1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 32'h0,         32'hA000_0014, 32'h14,        32'h18,        32'h18,        1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 32'h20,        32'h0000_0013, 32'h14,        32'h18,        32'h20,        1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 32'h103,       32'h0000_0013, 32'h14,        32'h18,        32'h100,       1'b0, 1'b0}; // redirect beats stall
    vecs[16] = '{1'b0, 1'b0, 32'h0,         32'hA000_0100, 32'h100,       32'h104,       32'h104,       1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0000_0013, 32'h100,       32'h104,       32'hFFFF_FFFC, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 32'h0,         32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b1, 1'b0}; // wrap
    vecs[19] = '{1'b0, 1'b0, 32'h0,         32'h0000_0013, 32'h0,         32'h4,         32'h4,         1'b1, 1'b0};

    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    reset       = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    check_all("reset", 32'h0000_0013, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step(vecs[i].stall, vecs[i].redirect, vecs[i].rpc);
      check_all($sformatf("vec%0d", i), vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_pc4,
                vecs[i].e_addr, vecs[i].e_valid, vecs[i].e_halted);
    end

    // Asynchronous reset between edges while in RUN (PC=4).
    #2;
    reset = 1'b1;
    #1;
    check_all("async_rst_run", 32'h0000_0013, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // START ignores stall; RUN then honours it; then the first fetch.
    step(1'b1, 1'b0, 32'h0);
    check_all("start_stall", 32'h0000_0013, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0);
    check_all("run_stall", 32'h0000_0013, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    check_all("first_fetch", 32'h0000_0013, 32'h0, 32'h4, 32'h4, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check_all("halt_again", 32'h0010_0073, 32'h8, 32'hC, 32'hC, 1'b1, 1'b1);

    // Stall right at HALT entry keeps the EBREAK valid.
    step(1'b1, 1'b0, 32'h0);
    check_all("halt_stall_hold", 32'h0010_0073, 32'h8, 32'hC, 32'hC, 1'b1, 1'b1);

    // Asynchronous reset while halted and stalled with a pending redirect.
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    #3;
    reset = 1'b1;
    #1;
    check_all("async_rst_halt", 32'h0000_0013, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    check_all("rst_held", 32'h0000_0013, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
